// File: rtl/p_hit_seq.sv
// Ray/plane hit point: t = n.(v0-origin) / n.dir, P = origin + t*dir, one ray in flight at a time.
// Latency: WIDTH+Q_BITS+4 cycles from input pop to output valid (3 for a parallel ray).
// Backpressure: pushes while in_full are dropped; a full output FIFO stalls the FSM in WRITE.

module p_hit_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         rd_en,
    output logic [W-1:0] dout,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Head is shown combinationally (fall-through); forced to zero while empty.
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en && !full) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
endmodule

module p_hit_seq #(
    parameter int WIDTH      = 32,
    parameter int Q_BITS     = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0][WIDTH-1:0] tri_normal,
    input  logic [2:0][WIDTH-1:0] v0,
    input  logic [2:0][WIDTH-1:0] origin,
    input  logic [2:0][WIDTH-1:0] dir,
    input  logic                  in_wr_en,
    output logic                  in_full,
    output logic [2:0][WIDTH-1:0] out_point,
    output logic [WIDTH-1:0]      out_t,
    output logic                  out_hit,
    input  logic                  out_rd_en,
    output logic                  out_empty
);
    localparam int DW = WIDTH + Q_BITS;
    localparam int CW = $clog2(DW + 1);

    typedef struct packed {
        logic [2:0][WIDTH-1:0] n;
        logic [2:0][WIDTH-1:0] v0;
        logic [2:0][WIDTH-1:0] org;
        logic [2:0][WIDTH-1:0] dir;
    } ray_t;

    typedef struct packed {
        logic [2:0][WIDTH-1:0] point;
        logic [WIDTH-1:0]      t;
        logic                  hit;
    } res_t;

    typedef enum logic [2:0] {S_IDLE, S_DOT, S_CHK, S_DIV, S_MUL, S_WRITE} state_t;

    // Full signed product, widened so three of them can be summed without overflow.
    function automatic logic signed [2*WIDTH+1:0] smul(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH+1:0] ae;
        logic signed [2*WIDTH+1:0] be;
        ae = {{(WIDTH+2){a[WIDTH-1]}}, a};
        be = {{(WIDTH+2){b[WIDTH-1]}}, b};
        return ae * be;
    endfunction

    state_t            state_q, state_d;
    ray_t              ray_q, ray_d, in_head;
    res_t              out_head, wr_res;
    logic [WIDTH-1:0]  num_q, num_d, den_q, den_d;
    logic              sign_q, sign_d;
    logic [WIDTH-1:0]  den_abs_q, den_abs_d, num_abs;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [DW-1:0]     quo_q, quo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  t_q, t_d;
    logic [2:0][WIDTH-1:0] point_q, point_d;
    logic              hit_q, hit_d;
    logic              in_empty, in_pop, out_full, out_push;
    logic [WIDTH:0]    trial, diff;
    logic              ge;
    logic [WIDTH-1:0]  mag, t_mul;
    logic signed [2*WIDTH+1:0] num_acc, den_acc;

    p_hit_fifo #(.W($bits(ray_t)), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clock(clock), .reset(reset),
        .wr_en(in_wr_en), .din({tri_normal, v0, origin, dir}), .full(in_full),
        .rd_en(in_pop), .dout(in_head), .empty(in_empty)
    );

    assign wr_res = '{point: point_q, t: t_q, hit: hit_q};

    p_hit_fifo #(.W($bits(res_t)), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clock(clock), .reset(reset),
        .wr_en(out_push), .din(wr_res), .full(out_full),
        .rd_en(out_rd_en), .dout(out_head), .empty(out_empty)
    );

    assign out_point = out_head.point;
    assign out_t     = out_head.t;
    assign out_hit   = out_head.hit;

    always_comb begin
        num_acc = '0;
        den_acc = '0;
        for (int i = 0; i < 3; i++) begin
            num_acc = num_acc + smul(ray_q.n[i], ray_q.v0[i] - ray_q.org[i]);
            den_acc = den_acc + smul(ray_q.n[i], ray_q.dir[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        ray_d     = ray_q;
        num_d     = num_q;
        den_d     = den_q;
        sign_d    = sign_q;
        den_abs_d = den_abs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        t_d       = t_q;
        point_d   = point_q;
        hit_d     = hit_q;
        in_pop    = 1'b0;
        out_push  = 1'b0;
        num_abs   = num_q[WIDTH-1] ? -num_q : num_q;
        trial     = {rem_q, quo_q[DW-1]};
        diff      = trial - {1'b0, den_abs_q};
        ge        = (trial >= {1'b0, den_abs_q});
        // Quotients at or above 2^(WIDTH-1) clamp to the largest representable magnitude.
        mag       = (|quo_q[DW-1:WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}} : quo_q[WIDTH-1:0];
        t_mul     = sign_q ? -mag : mag;

        case (state_q)
            S_IDLE: begin
                if (!in_empty) begin
                    in_pop  = 1'b1;
                    ray_d   = in_head;
                    state_d = S_DOT;
                end
            end
            S_DOT: begin
                num_d   = WIDTH'(num_acc >>> Q_BITS);
                den_d   = WIDTH'(den_acc >>> Q_BITS);
                state_d = S_CHK;
            end
            S_CHK: begin
                if (den_q == '0) begin
                    t_d     = '0;
                    point_d = '0;
                    hit_d   = 1'b0;
                    state_d = S_WRITE;
                end else begin
                    sign_d    = num_q[WIDTH-1] ^ den_q[WIDTH-1];
                    den_abs_d = den_q[WIDTH-1] ? -den_q : den_q;
                    rem_d     = '0;
                    quo_d     = {num_abs, {Q_BITS{1'b0}}};
                    cnt_d     = CW'(DW - 1);
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d = {quo_q[DW-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                t_d   = t_mul;
                hit_d = !t_mul[WIDTH-1];
                for (int i = 0; i < 3; i++) begin
                    point_d[i] = t_mul[WIDTH-1] ? '0
                               : ray_q.org[i] + WIDTH'(smul(t_mul, ray_q.dir[i]) >>> Q_BITS);
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!out_full) begin
                    out_push = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ray_q     <= '0;
            num_q     <= '0;
            den_q     <= '0;
            sign_q    <= 1'b0;
            den_abs_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            t_q       <= '0;
            point_q   <= '0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ray_q     <= ray_d;
            num_q     <= num_d;
            den_q     <= den_d;
            sign_q    <= sign_d;
            den_abs_q <= den_abs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            t_q       <= t_d;
            point_q   <= point_d;
            hit_q     <= hit_d;
        end
    end
endmodule
